// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, the
// priority case that is selected each cycle, and the per-stage control
// action bundle with its fixed encodings.
package hazard_pkg;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_FAULT    = 2'd2
  } state_e;

  // Which hazard case drives the pipeline this cycle (highest wins).
  typedef enum logic [2:0] {
    SEL_RUN       = 3'd0,
    SEL_LOAD_USE  = 3'd1,
    SEL_BRANCH    = 3'd2,
    SEL_MEM_STALL = 3'd3,
    SEL_FAULT     = 3'd4,
    SEL_RESET     = 3'd5
  } sel_e;

  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic ifid_flush;
    logic idex_we;
    logic idex_bubble;
    logic exmem_we;
    logic memwb_bubble;
  } ctrl_t;

  //                                   pc  ifid flush idex bub exmem mwb
  localparam ctrl_t CTRL_RUN       = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam ctrl_t CTRL_LOAD_USE  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam ctrl_t CTRL_BRANCH    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam ctrl_t CTRL_MEM_STALL = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam ctrl_t CTRL_FAULT     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam ctrl_t CTRL_RESET     = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard
// controller (slave). Building with HAZARD_PERF_CNT_EN adds the three
// performance counter outputs.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int PERF_CNT_W = 32
);
  logic [REG_ADDR_W-1:0] IF_ID_RS1;
  logic [REG_ADDR_W-1:0] IF_ID_RS2;
  logic                  ID_ID_UsesRS2;
  logic [REG_ADDR_W-1:0] ID_EX_Rd;
  logic                  ID_EX_MemRead;
  logic                  EX_BranchTaken;
  logic                  EX_MEM_MemReq;
  logic                  Mem_Ready;

  logic PCWrite;
  logic IF_ID_Write;
  logic IF_ID_Flush;
  logic ID_EX_Write;
  logic ID_EX_Bubble;
  logic EX_MEM_Write;
  logic MEM_WB_Bubble;
  logic Mem_Timeout;
  logic Halt;

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] Load_Stall_Cnt;
  logic [PERF_CNT_W-1:0] Mem_Stall_Cnt;
  logic [PERF_CNT_W-1:0] Flush_Cnt;
`endif

  modport master (
`ifdef HAZARD_PERF_CNT_EN
    input  Load_Stall_Cnt, Mem_Stall_Cnt, Flush_Cnt,
`endif
    output IF_ID_RS1, IF_ID_RS2, ID_ID_UsesRS2, ID_EX_Rd, ID_EX_MemRead,
           EX_BranchTaken, EX_MEM_MemReq, Mem_Ready,
    input  PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Bubble,
           EX_MEM_Write, MEM_WB_Bubble, Mem_Timeout, Halt
  );

  modport slave (
`ifdef HAZARD_PERF_CNT_EN
    output Load_Stall_Cnt, Mem_Stall_Cnt, Flush_Cnt,
`endif
    input  IF_ID_RS1, IF_ID_RS2, ID_ID_UsesRS2, ID_EX_Rd, ID_EX_MemRead,
           EX_BranchTaken, EX_MEM_MemReq, Mem_Ready,
    output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Bubble,
           EX_MEM_Write, MEM_WB_Bubble, Mem_Timeout, Halt
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_timeout_cnt.sv
// Memory wait counter: counts consecutive stalled cycles and flags the
// cycle on which one more stall means a timeout. Saturates, never wraps.
module hazard_timeout_cnt #(
  parameter int MEM_TIMEOUT = 16,
  localparam int CNT_W = $clog2(MEM_TIMEOUT) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             load_one,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             at_limit
);

  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Wait-cycle count; cleared when the wait ends, saturating while it lasts.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n)                   cnt <= '0;
    else if (clr)                   cnt <= '0;
    else if (load_one)              cnt <= CNT_W'(1);
    else if (inc && cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
  end

  assign at_limit = (cnt == LIMIT);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall sequencer for the 5-stage RV32I pipeline: load-use
// stalls, taken-branch flushes, data-memory waits and a timeout fault.
// Optional build macro HAZARD_PERF_CNT_EN adds saturating counters for
// load-use stalls, memory-stall cycles and branch flushes.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int PERF_CNT_W  = 32
) (
  input logic                   clk,
  input logic                   reset_n,
  pipeline_hazard_ctrl_if.slave bus
);

  state_e                state_q, state_d;
  logic                  timeout_q, timeout_d;
  logic                  mem_stall, load_use, at_limit;
  logic                  cnt_clr, cnt_load, cnt_inc;
  logic [REG_ADDR_W-1:0] ex_rd;
  sel_e                  sel;
  ctrl_t                 ctrl;

  assign ex_rd     = bus.ID_EX_Rd;
  assign mem_stall = bus.EX_MEM_MemReq & ~bus.Mem_Ready;
  assign load_use  = bus.ID_EX_MemRead & (ex_rd != '0) &
                     ((ex_rd == bus.IF_ID_RS1) |
                      (bus.ID_ID_UsesRS2 & (ex_rd == bus.IF_ID_RS2)));

  hazard_timeout_cnt #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (cnt_clr),
    .load_one (cnt_load),
    .inc      (cnt_inc),
    .cnt      (),
    .at_limit (at_limit)
  );

  // State register and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_RUN;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
    end
  end

  // Next state and wait-counter control.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    timeout_d = timeout_q;
    cnt_clr   = 1'b0;
    cnt_load  = 1'b0;
    cnt_inc   = 1'b0;
    case (state_q)
      S_RUN: begin
        if (mem_stall) begin
          state_d  = S_MEM_WAIT;
          cnt_load = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        if (!mem_stall) begin
          state_d = S_RUN;
          cnt_clr = 1'b1;
        end else begin
          cnt_inc = 1'b1;
          if (at_limit) begin
            state_d   = S_FAULT;
            timeout_d = 1'b1;
          end
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_RUN;
    endcase
  end

  // Pick the highest-priority case active this cycle.
  always_comb begin
    sel = SEL_RUN;
    if (!reset_n)                 sel = SEL_RESET;
    else if (state_q == S_FAULT)  sel = SEL_FAULT;
    else if (mem_stall)           sel = SEL_MEM_STALL;
    else if (bus.EX_BranchTaken)  sel = SEL_BRANCH;
    else if (load_use)            sel = SEL_LOAD_USE;
  end

  // Map the selected case onto stage enables, flushes and bubbles.
  always_comb begin
    case (sel)
      SEL_RESET:     ctrl = CTRL_RESET;
      SEL_FAULT:     ctrl = CTRL_FAULT;
      SEL_MEM_STALL: ctrl = CTRL_MEM_STALL;
      SEL_BRANCH:    ctrl = CTRL_BRANCH;
      SEL_LOAD_USE:  ctrl = CTRL_LOAD_USE;
      default:       ctrl = CTRL_RUN;
    endcase
  end

  assign bus.PCWrite       = ctrl.pc_we;
  assign bus.IF_ID_Write   = ctrl.ifid_we;
  assign bus.IF_ID_Flush   = ctrl.ifid_flush;
  assign bus.ID_EX_Write   = ctrl.idex_we;
  assign bus.ID_EX_Bubble  = ctrl.idex_bubble;
  assign bus.EX_MEM_Write  = ctrl.exmem_we;
  assign bus.MEM_WB_Bubble = ctrl.memwb_bubble;
  assign bus.Halt          = (sel == SEL_FAULT);
  assign bus.Mem_Timeout   = reset_n & timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] load_cnt_q, mem_cnt_q, flush_cnt_q;

  // Saturating event counters; a fault selects no counted case, so they freeze.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      load_cnt_q  <= '0;
      mem_cnt_q   <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (sel == SEL_LOAD_USE && load_cnt_q != '1)
        load_cnt_q <= load_cnt_q + PERF_CNT_W'(1);
      if (sel == SEL_MEM_STALL && mem_cnt_q != '1)
        mem_cnt_q <= mem_cnt_q + PERF_CNT_W'(1);
      if (sel == SEL_BRANCH && flush_cnt_q != '1)
        flush_cnt_q <= flush_cnt_q + PERF_CNT_W'(1);
    end
  end

  assign bus.Load_Stall_Cnt = load_cnt_q;
  assign bus.Mem_Stall_Cnt  = mem_cnt_q;
  assign bus.Flush_Cnt      = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MEM_TIMEOUT=16). Output vector
// order: {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Bubble,
// EX_MEM_Write, MEM_WB_Bubble, Halt, Mem_Timeout}.
module tb_pipeline_hazard_ctrl;
  import hazard_pkg::*;

  localparam logic [8:0] O_RUN   = 9'b110101000;
  localparam logic [8:0] O_RESET = 9'b001010100;
  localparam logic [8:0] O_MEM   = 9'b000000100;
  localparam logic [8:0] O_BR    = 9'b111111000;
  localparam logic [8:0] O_LU    = 9'b000111000;
  localparam logic [8:0] O_FAULT = 9'b000000011;

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.REG_ADDR_W(5), .PERF_CNT_W(32)) hif ();

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .MEM_TIMEOUT(16), .PERF_CNT_W(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (hif)
  );

  logic [8:0] outs;
  assign outs = {hif.PCWrite, hif.IF_ID_Write, hif.IF_ID_Flush, hif.ID_EX_Write,
                 hif.ID_EX_Bubble, hif.EX_MEM_Write, hif.MEM_WB_Bubble,
                 hif.Halt, hif.Mem_Timeout};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic [8:0] exp);
    #2;
    check(tag, 32'(outs), 32'(exp));
  endtask

  task automatic idle();
    hif.IF_ID_RS1      = '0;
    hif.IF_ID_RS2      = '0;
    hif.ID_ID_UsesRS2  = 1'b0;
    hif.ID_EX_Rd       = '0;
    hif.ID_EX_MemRead  = 1'b0;
    hif.EX_BranchTaken = 1'b0;
    hif.EX_MEM_MemReq  = 1'b0;
    hif.Mem_Ready      = 1'b0;
  endtask

  task automatic load_use_rs1(input logic [4:0] rd);
    hif.ID_EX_MemRead = 1'b1;
    hif.ID_EX_Rd      = rd;
    hif.IF_ID_RS1     = rd;
  endtask

  task automatic stall_req();
    hif.EX_MEM_MemReq = 1'b1;
    hif.Mem_Ready     = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    // Reset: forced outputs while held, S_RUN afterwards.
    reset_n = 1'b0;
    idle();
    chk_outs("reset_outs", O_RESET);
    tick();
    check("reset_state", 32'(dut.state_q), 32'(S_RUN));
    check("reset_cnt", 32'(dut.u_wait_cnt.cnt), 32'd0);
    reset_n = 1'b1;
    chk_outs("run_idle", O_RUN);

    // Load-use on rs1 for one cycle; the bubble clears it next cycle.
    load_use_rs1(5'd5);
    chk_outs("lu_rs1", O_LU);
    tick();
    hif.ID_EX_MemRead = 1'b0;
    chk_outs("lu_after_bubble", O_RUN);

    // rd = x0 never stalls.
    load_use_rs1(5'd0);
    chk_outs("lu_x0", O_RUN);

    // rs2 match only counts when the ID instruction reads rs2.
    idle();
    hif.ID_EX_MemRead = 1'b1;
    hif.ID_EX_Rd      = 5'd9;
    hif.IF_ID_RS1     = 5'd3;
    hif.IF_ID_RS2     = 5'd9;
    hif.ID_ID_UsesRS2 = 1'b1;
    chk_outs("lu_rs2", O_LU);
    tick();
    hif.ID_ID_UsesRS2 = 1'b0;
    chk_outs("lu_rs2_unused", O_RUN);

    // Non-load producer does not stall.
    idle();
    hif.ID_EX_Rd  = 5'd7;
    hif.IF_ID_RS1 = 5'd7;
    chk_outs("no_load", O_RUN);

    // Branch beats load-use.
    load_use_rs1(5'd5);
    hif.EX_BranchTaken = 1'b1;
    chk_outs("br_over_lu", O_BR);
    tick();

    // Memory stall beats branch and load-use; Mem_Ready on the request cycle avoids it.
    stall_req();
    chk_outs("mem_over_br", O_MEM);
    hif.Mem_Ready = 1'b1;
    chk_outs("one_cycle_mem", O_BR);
    tick();
    check("one_cycle_state", 32'(dut.state_q), 32'(S_RUN));
    idle();

    // Three-cycle memory wait, then ready.
    stall_req();
    chk_outs("mw_c1", O_MEM);
    check("mw_c1_state", 32'(dut.state_q), 32'(S_RUN));
    tick();
    chk_outs("mw_c2", O_MEM);
    check("mw_c2_state", 32'(dut.state_q), 32'(S_MEM_WAIT));
    check("mw_c2_cnt", 32'(dut.u_wait_cnt.cnt), 32'd1);
    tick();
    chk_outs("mw_c3", O_MEM);
    check("mw_c3_cnt", 32'(dut.u_wait_cnt.cnt), 32'd2);
    tick();
    hif.Mem_Ready = 1'b1;
    chk_outs("mw_ready", O_RUN);
    check("mw_ready_state", 32'(dut.state_q), 32'(S_MEM_WAIT));
    tick();
    idle();
    check("mw_back_state", 32'(dut.state_q), 32'(S_RUN));
    check("mw_back_cnt", 32'(dut.u_wait_cnt.cnt), 32'd0);
    chk_outs("mw_back_outs", O_RUN);

    // Ready arriving on the 16th wait cycle wins over the timeout.
    stall_req();
    for (int c = 1; c <= 15; c++) tick();
    check("edge_cnt", 32'(dut.u_wait_cnt.cnt), 32'd15);
    hif.Mem_Ready = 1'b1;
    chk_outs("edge_ready", O_RUN);
    tick();
    idle();
    chk_outs("edge_no_fault", O_RUN);
    check("edge_state", 32'(dut.state_q), 32'(S_RUN));

    // Reset during cycle 5 of a wait.
    stall_req();
    for (int c = 1; c <= 4; c++) tick();
    reset_n = 1'b0;
    chk_outs("rst_mid_outs", O_RESET);
    tick();
    check("rst_mid_state", 32'(dut.state_q), 32'(S_RUN));
    check("rst_mid_cnt", 32'(dut.u_wait_cnt.cnt), 32'd0);
    chk_outs("rst_mid_held", O_RESET);
    reset_n = 1'b1;
    idle();
    chk_outs("rst_mid_release", O_RUN);
    tick();

    // Timeout: 16 stalled cycles, then terminal fault.
    stall_req();
    for (int c = 1; c <= 16; c++) begin
      chk_outs($sformatf("to_stall_%0d", c), O_MEM);
      tick();
    end
    chk_outs("to_fault", O_FAULT);
    check("to_state", 32'(dut.state_q), 32'(S_FAULT));
    hif.Mem_Ready      = 1'b1;
    hif.EX_BranchTaken = 1'b1;
    tick();
    chk_outs("to_terminal", O_FAULT);
    reset_n = 1'b0;
    idle();
    chk_outs("to_reset_outs", O_RESET);
    tick();
    reset_n = 1'b1;
    chk_outs("to_cleared", O_RUN);
    check("to_cleared_state", 32'(dut.state_q), 32'(S_RUN));

`ifdef HAZARD_PERF_CNT_EN
    // Counters: 2 load-use stalls, 3 mem-stall cycles, 1 flush.
    do_reset();
    check("pc_load_zero", hif.Load_Stall_Cnt, 32'd0);
    check("pc_mem_zero", hif.Mem_Stall_Cnt, 32'd0);
    check("pc_flush_zero", hif.Flush_Cnt, 32'd0);
    load_use_rs1(5'd4);
    tick();
    idle();
    tick();
    load_use_rs1(5'd6);
    tick();
    idle();
    stall_req();
    tick();
    tick();
    tick();
    hif.Mem_Ready = 1'b1;
    tick();
    idle();
    hif.EX_BranchTaken = 1'b1;
    tick();
    idle();
    tick();
    check("pc_load", hif.Load_Stall_Cnt, 32'd2);
    check("pc_mem", hif.Mem_Stall_Cnt, 32'd3);
    check("pc_flush", hif.Flush_Cnt, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
